// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the CPU run controller: the sequencer state encoding and
// default memory geometry.
package cpu_run_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 8;

    typedef logic [DEF_ADDR_W:0] len_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        DUMP_RD,
        DUMP_TX,
        DONE
    } state_t;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Host, stream, data-memory and CPU-handshake signals of the run controller.
// slave = the controller itself, master = the host/bench side.
interface cpu_run_ctrl_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 32
);
    logic              go;
    logic [ADDR_W-1:0] load_base;
    logic [ADDR_W:0]   load_len;
    logic [ADDR_W-1:0] dump_base;
    logic [ADDR_W:0]   dump_len;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              mem_own;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              cpu_start;
    logic              cpu_halt;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [CNT_W-1:0]  cycle_count;

    modport slave (
        input  go, load_base, load_len, dump_base, dump_len,
               in_data, in_valid, out_ready, mem_rdata, cpu_halt,
        output in_ready, out_data, out_valid, mem_own, mem_addr, mem_wr,
               mem_rd, mem_wdata, cpu_start, busy, done, timeout, cycle_count
    );

    modport master (
        output go, load_base, load_len, dump_base, dump_len,
               in_data, in_valid, out_ready, mem_rdata, cpu_halt,
        input  in_ready, out_data, out_valid, mem_own, mem_addr, mem_wr,
               mem_rd, mem_wdata, cpu_start, busy, done, timeout, cycle_count
    );

endinterface

// File: rtl/cpu_run_ctrl_watchdog.sv
// RUN-phase cycle counter: saturating count of non-halt cycles plus the
// watchdog threshold compare.
module run_watchdog #(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             halt,
    output logic [CNT_W-1:0] count,
    output logic             expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_q, count_d;

    assign expired = (count_q >= LIMIT);
    assign count   = count_q;

    // Counting stops once the limit is reached so the reported value is the threshold itself.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !halt && !expired && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Host-side sequencer: loads data memory from a byte stream, pulses cpu_start,
// waits for Halt under a watchdog, then streams a memory window back out.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned START_CYCLES   = 2,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic           CLK,
    input  logic           rst_n,
    cpu_run_ctrl_if.slave  bus
);

    localparam int unsigned SC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

    state_t            state_q;
    logic [ADDR_W:0]   idx_q;
    logic [ADDR_W-1:0] load_base_q, dump_base_q;
    logic [ADDR_W:0]   load_len_q, dump_len_q;
    logic [DATA_W-1:0] out_data_q;
    logic [SC_W-1:0]   start_cnt_q;
    logic              timeout_q;

    logic              wd_clear, wd_expired;
    logic [CNT_W-1:0]  wd_count;

    assign wd_clear = (state_q == IDLE) && bus.go;

    run_watchdog #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .CLK     (CLK),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .enable  (state_q == RUN),
        .halt    (bus.cpu_halt),
        .count   (wd_count),
        .expired (wd_expired)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            load_base_q <= '0;
            dump_base_q <= '0;
            load_len_q  <= '0;
            dump_len_q  <= '0;
            out_data_q  <= '0;
            start_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            start_cnt_q <= '0;
            case (state_q)
                IDLE: begin
                    if (bus.go) begin
                        load_base_q <= bus.load_base;
                        dump_base_q <= bus.dump_base;
                        load_len_q  <= bus.load_len;
                        dump_len_q  <= bus.dump_len;
                        idx_q       <= '0;
                        timeout_q   <= 1'b0;
                        state_q     <= (bus.load_len == '0) ? START : LOAD;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        idx_q <= idx_q + 1'b1;
                        if (idx_q == load_len_q - 1'b1) begin
                            state_q <= START;
                        end
                    end
                end
                START: begin
                    start_cnt_q <= start_cnt_q + 1'b1;
                    if (start_cnt_q == SC_W'(START_CYCLES - 1)) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // Halt is tested first so it wins over a same-cycle watchdog expiry.
                    if (bus.cpu_halt) begin
                        idx_q   <= '0;
                        state_q <= (dump_len_q == '0) ? DONE : DUMP_RD;
                    end else if (wd_expired) begin
                        timeout_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DUMP_RD: begin
                    out_data_q <= bus.mem_rdata;
                    state_q    <= DUMP_TX;
                end
                DUMP_TX: begin
                    if (bus.out_ready) begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= (idx_q == dump_len_q - 1'b1) ? DONE : DUMP_RD;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.in_ready    = (state_q == LOAD);
    assign bus.mem_own     = (state_q == LOAD) || (state_q == DUMP_RD);
    assign bus.mem_wr      = (state_q == LOAD) && bus.in_valid;
    assign bus.mem_rd      = (state_q == DUMP_RD);
    assign bus.mem_wdata   = (state_q == LOAD) ? bus.in_data : '0;
    assign bus.mem_addr    = (state_q == LOAD)    ? load_base_q + idx_q[ADDR_W-1:0] :
                             (state_q == DUMP_RD) ? dump_base_q + idx_q[ADDR_W-1:0] : '0;
    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = (state_q == DUMP_TX);
    assign bus.cpu_start   = (state_q == START);
    assign bus.done        = (state_q == DONE);
    assign bus.timeout     = timeout_q;
    assign bus.cycle_count = wd_count;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: behavioural data memory, a CPU halt model
// and a negedge monitor logging writes, dumped bytes, start width and done pulses.
module tb_cpu_run_ctrl;

    logic CLK = 1'b0;
    logic rst_n;

    always #5 CLK = ~CLK;

    cpu_run_ctrl_if #(.ADDR_W(8), .DATA_W(8), .CNT_W(32)) bus ();

    cpu_run_ctrl #(
        .ADDR_W         (8),
        .DATA_W         (8),
        .START_CYCLES   (2),
        .CNT_W          (32),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] tb_mem [256];
    assign bus.mem_rdata = tb_mem[bus.mem_addr];

    always @(posedge CLK) begin
        if (bus.mem_wr) tb_mem[bus.mem_addr] <= bus.mem_wdata;
    end

    // CPU model: raise halt once halt_after non-halt RUN cycles have elapsed after start falls.
    int halt_after = -1;
    int run_ctr    = 0;
    bit start_prev = 0;
    initial begin
        bus.cpu_halt = 1'b0;
        forever begin
            @(posedge CLK); #1;
            if (bus.cpu_start) begin
                start_prev   = 1;
                run_ctr      = 0;
                bus.cpu_halt = 1'b0;
            end else if (start_prev) begin
                run_ctr++;
                if (run_ctr == halt_after + 1) begin
                    bus.cpu_halt = 1'b1;
                end else begin
                    bus.cpu_halt = 1'b0;
                    if (halt_after >= 0 && run_ctr > halt_after + 1) start_prev = 0;
                end
            end
        end
    end

    bit toggle_rdy = 0;
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge CLK); #1;
            bus.out_ready = toggle_rdy ? ~bus.out_ready : 1'b1;
        end
    end

    logic [7:0] wr_addr [$];
    logic [7:0] wr_data [$];
    logic [7:0] out_q   [$];
    int         ov_cnt, done_cnt, st_run, last_start_len;
    bit         prev_stall;
    logic [7:0] prev_data;

    always @(negedge CLK) begin
        if (bus.mem_wr) begin
            wr_addr.push_back(bus.mem_addr);
            wr_data.push_back(bus.mem_wdata);
            check_eq("own_on_wr", {31'd0, bus.mem_own}, 32'd1);
        end
        if (bus.mem_rd) check_eq("own_on_rd", {31'd0, bus.mem_own}, 32'd1);
        if (bus.out_valid) begin
            ov_cnt++;
            if (prev_stall) check_eq("dump_hold", {24'd0, bus.out_data}, {24'd0, prev_data});
            if (bus.out_ready) out_q.push_back(bus.out_data);
            prev_stall = !bus.out_ready;
            prev_data  = bus.out_data;
        end else begin
            prev_stall = 0;
        end
        if (bus.done) done_cnt++;
        if (bus.cpu_start) begin
            st_run++;
        end else if (st_run != 0) begin
            last_start_len = st_run;
            st_run         = 0;
        end
    end

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        out_q.delete();
        ov_cnt         = 0;
        done_cnt       = 0;
        st_run         = 0;
        last_start_len = 0;
        prev_stall     = 0;
    endtask

    task automatic start_seq(input logic [7:0] lb, input logic [8:0] ll,
                             input logic [7:0] db, input logic [8:0] dl, input int ha);
        @(posedge CLK); #1;
        clear_logs();
        halt_after    = ha;
        bus.load_base = lb;
        bus.load_len  = ll;
        bus.dump_base = db;
        bus.dump_len  = dl;
        bus.go        = 1'b1;
        @(posedge CLK); #1;
        bus.go        = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input int n);
        logic [7:0] bytes [4];
        int k, guard;
        bit hs;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
        k = 0; guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = bytes[0];
        while (k < n && guard < 100) begin
            @(negedge CLK);
            hs = bus.in_ready;
            @(posedge CLK); #1;
            if (hs) begin
                k++;
                if (k < n) bus.in_data = bytes[k];
            end
            guard++;
        end
        bus.in_valid = 1'b0;
        check_eq("load_accepted", k, n);
    endtask

    task automatic wait_done(input int max_cycles);
        int c;
        c = 0;
        while (!bus.done && c < max_cycles) begin
            @(negedge CLK);
            c++;
        end
        check_eq("done_seen", {31'd0, bus.done}, 32'd1);
    endtask

    task automatic check_idle_after_done(input string tag);
        @(posedge CLK); #1;
        check_eq(tag, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 8'h00;
        rst_n         = 1'b0;
        bus.go        = 1'b0;
        bus.load_base = '0;
        bus.load_len  = '0;
        bus.dump_base = '0;
        bus.dump_len  = '0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        clear_logs();
        repeat (3) @(negedge CLK);

        check_eq("rst_busy",      {31'd0, bus.busy},      32'd0);
        check_eq("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        check_eq("rst_mem_own",   {31'd0, bus.mem_own},   32'd0);
        check_eq("rst_mem_wr",    {31'd0, bus.mem_wr},    32'd0);
        check_eq("rst_mem_rd",    {31'd0, bus.mem_rd},    32'd0);
        check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("rst_cpu_start", {31'd0, bus.cpu_start}, 32'd0);
        check_eq("rst_done",      {31'd0, bus.done},      32'd0);
        check_eq("rst_timeout",   {31'd0, bus.timeout},   32'd0);
        check_eq("rst_count",     bus.cycle_count,        32'd0);
        rst_n = 1'b1;

        // Load across the top of memory, halt after 10 cycles, dump 3 with stalls.
        toggle_rdy = 1;
        start_seq(8'hFE, 9'd4, 8'hFE, 9'd3, 10);
        check_eq("t1_busy", {31'd0, bus.busy}, 32'd1);
        send_bytes(8'h11, 8'h22, 8'h33, 8'h44, 4);
        wait_done(200);
        check_eq("t1_nwr", wr_addr.size(), 4);
        check_eq("t1_wa0", {24'd0, wr_addr[0]}, 32'hFE);
        check_eq("t1_wa1", {24'd0, wr_addr[1]}, 32'hFF);
        check_eq("t1_wa2", {24'd0, wr_addr[2]}, 32'h00);
        check_eq("t1_wa3", {24'd0, wr_addr[3]}, 32'h01);
        check_eq("t1_wd0", {24'd0, wr_data[0]}, 32'h11);
        check_eq("t1_wd3", {24'd0, wr_data[3]}, 32'h44);
        check_eq("t1_start_len", last_start_len, 2);
        check_eq("t1_nout", out_q.size(), 3);
        check_eq("t1_out0", {24'd0, out_q[0]}, 32'h11);
        check_eq("t1_out1", {24'd0, out_q[1]}, 32'h22);
        check_eq("t1_out2", {24'd0, out_q[2]}, 32'h33);
        check_eq("t1_count", bus.cycle_count, 32'd10);
        check_eq("t1_timeout", {31'd0, bus.timeout}, 32'd0);
        check_idle_after_done("t1_idle");
        check_eq("t1_done_cnt", done_cnt, 1);
        toggle_rdy = 0;

        // Watchdog: no halt ever.
        start_seq(8'h00, 9'd0, 8'h20, 9'd2, -1);
        wait_done(300);
        check_eq("to_timeout", {31'd0, bus.timeout}, 32'd1);
        check_eq("to_count", bus.cycle_count, 32'd50);
        check_eq("to_nout", ov_cnt, 0);
        check_idle_after_done("to_idle");
        check_eq("to_done_cnt", done_cnt, 1);
        check_eq("to_sticky", {31'd0, bus.timeout}, 32'd1);

        // Zero-length load and dump.
        start_seq(8'h30, 9'd0, 8'h30, 9'd0, 5);
        check_eq("z_timeout_clr", {31'd0, bus.timeout}, 32'd0);
        check_eq("z_count_clr", bus.cycle_count, 32'd0);
        wait_done(200);
        check_eq("z_nwr", wr_addr.size(), 0);
        check_eq("z_nout", ov_cnt, 0);
        check_eq("z_count", bus.cycle_count, 32'd5);
        check_eq("z_start_len", last_start_len, 2);
        check_idle_after_done("z_idle");

        // go during RUN must be ignored along with the config change.
        start_seq(8'h10, 9'd1, 8'h10, 9'd1, 8);
        send_bytes(8'h5A, 8'h00, 8'h00, 8'h00, 1);
        repeat (5) @(posedge CLK);
        #1;
        bus.go       = 1'b1;
        bus.dump_len = 9'd0;
        bus.load_len = 9'd5;
        @(posedge CLK); #1;
        bus.go = 1'b0;
        wait_done(200);
        check_eq("g_count", bus.cycle_count, 32'd8);
        check_eq("g_nout", out_q.size(), 1);
        check_eq("g_out0", {24'd0, out_q[0]}, 32'h5A);
        repeat (10) @(posedge CLK);
        #1;
        check_eq("g_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("g_done_cnt", done_cnt, 1);

        // Asynchronous reset in the middle of a load.
        start_seq(8'h80, 9'd4, 8'h80, 9'd0, 3);
        send_bytes(8'hC1, 8'hC2, 8'h00, 8'h00, 2);
        @(negedge CLK); #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_busy",     {31'd0, bus.busy},     32'd0);
        check_eq("ar_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check_eq("ar_mem_own",  {31'd0, bus.mem_own},  32'd0);
        check_eq("ar_count",    bus.cycle_count,       32'd0);
        repeat (3) @(negedge CLK);
        check_eq("ar_no_done", done_cnt, 0);
        rst_n = 1'b1;
        start_seq(8'h40, 9'd2, 8'h40, 9'd0, 3);
        send_bytes(8'hAA, 8'hBB, 8'h00, 8'h00, 2);
        wait_done(200);
        check_eq("ar_nwr",  wr_addr.size(), 2);
        check_eq("ar_wa0",  {24'd0, wr_addr[0]}, 32'h40);
        check_eq("ar_wd0",  {24'd0, wr_data[0]}, 32'hAA);
        check_eq("ar_wa1",  {24'd0, wr_addr[1]}, 32'h41);
        check_eq("ar_cnt3", bus.cycle_count, 32'd3);
        check_idle_after_done("ar_idle");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=stuck exp=finish");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Host-side initiator for the accumulator CPU's start/Halt handshake and its data memory.
- Receives a byte stream and writes it into data memory.
- Pulses the CPU's start, then waits for Halt with a watchdog.
- Streams a window of data memory back out and reports cycle count and status.
- Sits between the bench/host interface and the CPU top level; owns the data-memory port whenever the CPU is not running.

Parameters:
- ADDR_W, 8, data-memory address width.
- DATA_W, 8, data-memory word width.
- START_CYCLES, 2, number of cycles cpu_start is held high (minimum 1).
- CNT_W, 32, cycle counter width.
- TIMEOUT_CYCLES, 1000000, RUN cycles before the watchdog aborts.

Ports:
- CLK, input, 1, clock; all state changes on posedge.
- rst_n, input, 1, asynchronous active-low reset.
- go, input, 1, begin a sequence; sampled only in IDLE.
- load_base, input, ADDR_W, first address for loaded bytes.
- load_len, input, ADDR_W+1, number of bytes to load (0..256).
- dump_base, input, ADDR_W, first address to dump.
- dump_len, input, ADDR_W+1, number of bytes to dump (0..256).
- in_data, input, DATA_W, load stream data.
- in_valid, input, 1, load stream valid.
- in_ready, output, 1, load stream ready.
- out_data, output, DATA_W, dump stream data.
- out_valid, output, 1, dump stream valid.
- out_ready, input, 1, dump stream ready.
- mem_own, output, 1, high when this block drives the data memory; external mux selects it.
- mem_addr, output, ADDR_W, data-memory address.
- mem_wr, output, 1, write strobe.
- mem_rd, output, 1, read strobe.
- mem_wdata, output, DATA_W, write data.
- mem_rdata, input, DATA_W, read data; combinational, valid in the same cycle as mem_addr/mem_rd.
- cpu_start, output, 1, drives the CPU's start input.
- cpu_halt, input, 1, the CPU's Halt output.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse at sequence end.
- timeout, output, 1, sticky watchdog flag; cleared on the next accepted go.
- cycle_count, output, CNT_W, RUN cycles of the last sequence; held until the next go.

Behaviour:
- Clock port CLK, reset port rst_n; one clock domain; reset is asynchronous, active-low.
- Reset values: state IDLE; all outputs 0; cycle_count 0; timeout 0.
- Reset mid-operation aborts immediately: cpu_start drops and no partial done is generated.
- Configuration inputs are latched on the accepted go; later changes are ignored until the next sequence.
- go is ignored unless the state is IDLE.
- States: IDLE, LOAD, START, RUN, DUMP_RD, DUMP_TX, DONE.
- IDLE, on go: clear idx, cycle_count and timeout. Next state is LOAD, or START if load_len == 0.
- LOAD: mem_own=1, in_ready=1.
  - Each in_valid&&in_ready writes in_data to (load_base+idx) mod 2^ADDR_W in that cycle (mem_wr=1); idx++.
  - The cycle that accepts byte load_len-1 goes to START.
  - No write occurs when in_valid=0.
- START: mem_own=0, cpu_start=1 for exactly START_CYCLES cycles; cpu_halt is ignored.
- RUN: cpu_start=0, mem_own=0.
  - cycle_count increments each cycle cpu_halt=0.
  - cpu_halt=1 goes to DUMP_RD, or to DONE if dump_len == 0; cycle_count is not incremented that cycle.
  - cycle_count reaching TIMEOUT_CYCLES sets timeout=1 and goes to DONE with no dump.
  - If cpu_halt and the timeout threshold occur in the same cycle, halt wins and timeout stays 0.
- DUMP_RD: mem_own=1, mem_rd=1, mem_addr=(dump_base+idx) mod 2^ADDR_W; mem_rdata is registered into out_data; next state DUMP_TX.
- DUMP_TX: out_valid=1 with out_data stable until out_ready.
  - On out_valid&&out_ready: idx++; next state is DUMP_RD, or DONE after byte dump_len-1.
  - Throughput is one byte per 2 cycles minimum.
- DONE: done=1 for one cycle, then IDLE.
- Address wrap-around is modulo 2^ADDR_W. Length 256 covers the whole memory exactly once.
- cycle_count saturates at all-ones and never wraps.

Decomposition:
- Package cpu_run_ctrl_pkg holds the state enum (state_t), ADDR_W/DATA_W defaults, and a len_t typedef (ADDR_W+1 bits).
- One sub-module, run_watchdog, holds the cycle counter, saturation logic and timeout compare.
  - Inputs: CLK, rst_n, clear, enable, halt.
  - Outputs: count, expired.

Test Plan:
- Load 4 bytes {0x11,0x22,0x33,0x44} at base 0xFE with continuous in_valid → writes land at 0xFE, 0xFF, 0x00, 0x01; then cpu_start is high for exactly 2 cycles.
- CPU model asserts halt 10 cycles after start falls; dump_len=3 from base 0xFE with out_ready toggling every other cycle → out stream 0x11, 0x22, 0x33 with data held while stalled; cycle_count=10; done pulses once.
- Halt never asserted, TIMEOUT_CYCLES=50 → timeout=1, cycle_count=50, no out_valid, done pulse, return to IDLE.
- load_len=0 and dump_len=0, halt after 5 cycles → no mem_wr and no out_valid; cycle_count=5.
- go pulsed during RUN → ignored; configuration unchanged; only one done pulse.
- rst_n dropped mid-LOAD after 2 bytes → asynchronous return to IDLE, all outputs 0; a fresh go then loads from idx 0.
